// File: rtl/piano_sequencer_if.sv
// Key/switch inputs and tone-generator outputs of the piano sequencer.
interface piano_sequencer_if #(
  parameter int unsigned N_KEYS = 7,
  parameter int unsigned DEPTH  = 64
);
  localparam int unsigned NOTE_W = $clog2(N_KEYS + 1);
  localparam int unsigned AW     = $clog2(DEPTH);

  logic [N_KEYS-1:0] keys;
  logic [1:0]        octave;
  logic [2:0]        mode;
  logic              write_on;
  logic              start;
  logic [NOTE_W-1:0] note_out;
  logic [1:0]        octave_out;
  logic [N_KEYS-1:0] led_out;
  logic              busy;
  logic              rec_full;
  logic [AW:0]       event_count;
  logic [7:0]        hits;
  logic [7:0]        misses;
  logic              done;

  modport master (
    output keys, octave, mode, write_on, start,
    input  note_out, octave_out, led_out, busy, rec_full, event_count, hits, misses, done
  );

  modport slave (
    input  keys, octave, mode, write_on, start,
    output note_out, octave_out, led_out, busy, rec_full, event_count, hits, misses, done
  );
endinterface

// File: rtl/piano_sequencer.sv
// Piano controller with free play, event recording, auto playback and learn mode.
// Events are {note, octave, duration-in-ticks} stored in a small flop array.
module piano_sequencer #(
  parameter int unsigned N_KEYS   = 7,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  piano_sequencer_if.slave bus
);
  localparam int unsigned NOTE_W = $clog2(N_KEYS + 1);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned DW1    = DUR_W + 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0]  MODE_FREE  = 3'b100;
  localparam logic [2:0]  MODE_AUTO  = 3'b010;
  localparam logic [2:0]  MODE_LEARN = 3'b001;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [1:0]        oct;
    logic [DUR_W-1:0]  dur;
  } evt_t;

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY, S_LEARN} state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              start_s_q, start_s_d, start_p_q, start_p_d;
  logic              wr_s_q, wr_s_d, wr_p_q, wr_p_d;
  logic [CW-1:0]     count_q, count_d, idx_q, idx_d;
  logic              rec_full_q, rec_full_d, done_q, done_d, busy_q, busy_d;
  logic [7:0]        hits_q, hits_d, misses_q, misses_d;
  logic [NOTE_W-1:0] note_q, note_d, prev_note_q, prev_note_d;
  logic [1:0]        oct_q, oct_d;
  logic [N_KEYS-1:0] led_q, led_d;
  evt_t              open_q, open_d;
  logic [DUR_W-1:0]  pcnt_q, pcnt_d;

  evt_t              mem [DEPTH];
  logic              we_a, we_b;
  logic [AW-1:0]     wa_a, wa_b;
  evt_t              wd_a, wd_b;
  evt_t              rd_evt, rd_nxt;
  logic [NOTE_W-1:0] cur_note;
  logic              tick_c, start_rise, wr_rise, wr_fall, adv;

  function automatic logic [N_KEYS-1:0] note_led(input logic [NOTE_W-1:0] n);
    note_led = '0;
    if (n != '0) note_led = N_KEYS'(1) << (n - NOTE_W'(1));
  endfunction

  // Lowest pressed key wins.
  always_comb begin
    cur_note = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--)
      if (bus.keys[i]) cur_note = NOTE_W'(i + 1);
  end

  always_comb begin
    tick_c      = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d  = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    start_s_d   = bus.start;
    start_p_d   = start_s_q;
    wr_s_d      = bus.write_on;
    wr_p_d      = wr_s_q;
    start_rise  = start_s_q & ~start_p_q;
    wr_rise     = wr_s_q & ~wr_p_q;
    wr_fall     = ~wr_s_q & wr_p_q;
    prev_note_d = cur_note;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rec_full_d = rec_full_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    open_d     = open_q;
    idx_d      = idx_q;
    pcnt_d     = pcnt_q;
    done_d     = 1'b0;
    adv        = 1'b0;
    we_a       = 1'b0;
    wa_a       = '0;
    wd_a       = '0;
    we_b       = 1'b0;
    wa_b       = '0;
    wd_b       = '0;
    rd_evt     = mem[idx_q[AW-1:0]];

    unique case (state_q)
      S_IDLE: begin
        if (bus.mode == MODE_FREE && wr_rise) begin
          state_d     = S_REC;
          count_d     = '0;
          rec_full_d  = 1'b0;
          open_d.note = cur_note;
          open_d.oct  = bus.octave;
          open_d.dur  = '0;
        end else if (start_rise && count_q != '0 &&
                     (bus.mode == MODE_AUTO || bus.mode == MODE_LEARN)) begin
          state_d = (bus.mode == MODE_AUTO) ? S_PLAY : S_LEARN;
          idx_d   = '0;
          pcnt_d  = '0;
          if (bus.mode == MODE_LEARN) begin
            hits_d   = '0;
            misses_d = '0;
          end
        end
      end
      S_REC: begin
        // Tick update first, then a possible end-of-recording flush in the same cycle.
        if (tick_c) begin
          if (cur_note == open_q.note && bus.octave == open_q.oct) begin
            if (open_q.dur != '1) open_d.dur = open_q.dur + DUR_W'(1);
          end else begin
            if (open_q.dur != '0) begin
              we_a    = 1'b1;
              wa_a    = count_q[AW-1:0];
              wd_a    = open_q;
              count_d = count_q + CW'(1);
            end
            open_d.note = cur_note;
            open_d.oct  = bus.octave;
            open_d.dur  = DUR_W'(1);
          end
        end
        if (count_d == CW'(DEPTH)) begin
          rec_full_d = 1'b1;
          state_d    = S_IDLE;
        end else if (wr_fall || bus.mode != MODE_FREE) begin
          if (open_d.dur != '0) begin
            we_b    = 1'b1;
            wa_b    = count_d[AW-1:0];
            wd_b    = open_d;
            count_d = count_d + CW'(1);
          end
          rec_full_d = (count_d == CW'(DEPTH));
          state_d    = S_IDLE;
        end
      end
      S_PLAY: begin
        if (bus.mode != MODE_AUTO) begin
          state_d = S_IDLE;
        end else if (tick_c) begin
          if (DW1'(pcnt_q) + DW1'(1) >= DW1'(rd_evt.dur)) begin
            pcnt_d = '0;
            adv    = 1'b1;
          end else begin
            pcnt_d = pcnt_q + DUR_W'(1);
          end
        end
      end
      S_LEARN: begin
        if (bus.mode != MODE_LEARN) begin
          state_d = S_IDLE;
        end else if (rd_evt.note == '0) begin
          adv = 1'b1;
        end else if (cur_note != prev_note_q && cur_note != '0) begin
          if (cur_note == rd_evt.note) begin
            hits_d = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
            adv    = 1'b1;
          end else begin
            misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
          end
        end
      end
    endcase

    if (adv) begin
      idx_d = idx_q + CW'(1);
      if (idx_d == count_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // Outputs follow the state being entered so event boundaries have no gap.
    rd_nxt = mem[idx_d[AW-1:0]];
    note_d = '0;
    oct_d  = '0;
    led_d  = '0;
    unique case (state_d)
      S_IDLE, S_REC: begin
        if (bus.mode == MODE_FREE) begin
          note_d = cur_note;
          oct_d  = bus.octave;
          led_d  = bus.keys;
        end
      end
      S_PLAY: begin
        note_d = rd_nxt.note;
        oct_d  = rd_nxt.oct;
        led_d  = note_led(rd_nxt.note);
      end
      S_LEARN: begin
        note_d = cur_note;
        oct_d  = rd_nxt.oct;
        led_d  = note_led(rd_nxt.note);
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      start_s_q   <= 1'b0;
      start_p_q   <= 1'b0;
      wr_s_q      <= 1'b0;
      wr_p_q      <= 1'b0;
      count_q     <= '0;
      idx_q       <= '0;
      rec_full_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      hits_q      <= '0;
      misses_q    <= '0;
      note_q      <= '0;
      prev_note_q <= '0;
      oct_q       <= '0;
      led_q       <= '0;
      open_q      <= '0;
      pcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      start_s_q   <= start_s_d;
      start_p_q   <= start_p_d;
      wr_s_q      <= wr_s_d;
      wr_p_q      <= wr_p_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      rec_full_q  <= rec_full_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      note_q      <= note_d;
      prev_note_q <= prev_note_d;
      oct_q       <= oct_d;
      led_q       <= led_d;
      open_q      <= open_d;
      pcnt_q      <= pcnt_d;
    end
  end

  // Event storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we_a) mem[wa_a] <= wd_a;
    if (we_b) mem[wa_b] <= wd_b;
  end

  assign bus.note_out    = note_q;
  assign bus.octave_out  = oct_q;
  assign bus.led_out     = led_q;
  assign bus.busy        = busy_q;
  assign bus.rec_full    = rec_full_q;
  assign bus.event_count = count_q;
  assign bus.hits        = hits_q;
  assign bus.misses      = misses_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_piano_sequencer.sv
// Directed bench for piano_sequencer: free-play vector table plus record,
// playback, learn, full-buffer, abort and reset sequences.
module tb_piano_sequencer;
  localparam int unsigned N_KEYS   = 7;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DUR_W    = 12;
  localparam int unsigned TICK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piano_sequencer_if #(.N_KEYS(N_KEYS), .DEPTH(DEPTH)) bus ();

  piano_sequencer #(
    .N_KEYS(N_KEYS), .DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [2:0] mode;
    logic [6:0] keys;
    logic [1:0] oct;
    int         exp_note;
    int         exp_oct;
    logic [6:0] exp_led;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   run_note[16];
  int   run_len[16];
  int   runs_n;
  bit   fin;
  bit   busy_max;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b100, 7'b0000101, 2'd2, 1, 2, 7'b0000101};
    vecs[1] = '{3'b100, 7'b0000000, 2'd2, 0, 2, 7'b0000000};
    vecs[2] = '{3'b100, 7'b1000000, 2'd1, 7, 1, 7'b1000000};
    vecs[3] = '{3'b100, 7'b1111110, 2'd3, 2, 3, 7'b1111110};
    vecs[4] = '{3'b010, 7'b0000101, 2'd2, 0, 0, 7'b0000000};
    vecs[5] = '{3'b001, 7'b0000101, 2'd2, 0, 0, 7'b0000000};
    vecs[6] = '{3'b000, 7'b0000100, 2'd1, 0, 0, 7'b0000000};
    vecs[7] = '{3'b110, 7'b0011000, 2'd3, 0, 0, 7'b0000000};

    reset        = 1'b1;
    bus.keys     = '0;
    bus.octave   = '0;
    bus.mode     = '0;
    bus.write_on = 1'b0;
    bus.start    = 1'b0;
    cyc(2);
    chk("rst_note", 32'(bus.note_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_count", 32'(bus.event_count), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset = 1'b0;
    cyc(1);

    // Free play / idle output table
    for (int v = 0; v < 8; v++) begin
      bus.mode   = vecs[v].mode;
      bus.keys   = vecs[v].keys;
      bus.octave = vecs[v].oct;
      cyc(1);
      chk($sformatf("vec%0d_note", v), 32'(bus.note_out), 32'(vecs[v].exp_note));
      chk($sformatf("vec%0d_oct", v), 32'(bus.octave_out), 32'(vecs[v].exp_oct));
      chk($sformatf("vec%0d_led", v), 32'(bus.led_out), 32'(vecs[v].exp_led));
      chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 0);
    end

    // Record: key3 5 ticks, rest 2 ticks, key5 3 ticks
    bus.mode     = 3'b100;
    bus.octave   = 2'd2;
    bus.keys     = 7'b0000100;
    bus.write_on = 1'b1;
    cyc(1);
    chk("rec_lat1_busy", 32'(bus.busy), 0);
    cyc(1);
    chk("rec_busy", 32'(bus.busy), 1);
    chk("rec_count0", 32'(bus.event_count), 0);
    cyc(18);
    bus.keys = 7'b0000000;
    cyc(8);
    bus.keys = 7'b0010000;
    cyc(12);
    bus.write_on = 1'b0;
    cyc(1);
    chk("rec_fall_lat1", 32'(bus.busy), 1);
    cyc(1);
    chk("rec_fall_idle", 32'(bus.busy), 0);
    bus.keys = '0;
    cyc(1);
    chk("rec_count", 32'(bus.event_count), 3);
    chk("rec_not_full", 32'(bus.rec_full), 0);

    // Auto playback
    bus.mode = 3'b010;
    cyc(2);
    done_seen = 0;
    bus.start = 1'b1;
    cyc(1);
    chk("play_lat1_busy", 32'(bus.busy), 0);
    cyc(1);
    chk("play_busy", 32'(bus.busy), 1);
    chk("play_first_note", 32'(bus.note_out), 3);
    chk("play_first_led", 32'(bus.led_out), 32'(7'b0000100));
    chk("play_first_oct", 32'(bus.octave_out), 2);
    bus.start = 1'b0;
    runs_n = 0;
    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (bus.busy === 1'b1) begin
        if (runs_n == 0 || int'(bus.note_out) != run_note[runs_n-1]) begin
          if (runs_n < 16) begin
            run_note[runs_n] = int'(bus.note_out);
            run_len[runs_n]  = 1;
            runs_n++;
          end else begin
            fin = 1'b1;
          end
        end else begin
          run_len[runs_n-1]++;
        end
      end else if (runs_n > 0) begin
        fin = 1'b1;
      end
      if (!fin) cyc(1);
    end
    chk("play_finished", 32'(fin), 1);
    chk("play_runs", 32'(runs_n), 3);
    if (runs_n == 3) begin
      chk("play_note0", 32'(run_note[0]), 3);
      chk("play_note1", 32'(run_note[1]), 0);
      chk("play_note2", 32'(run_note[2]), 5);
      chk_rng("play_len0", run_len[0], 13, 24);
      chk_rng("play_len1", run_len[1], 4, 12);
      chk_rng("play_len2", run_len[2], 8, 16);
    end
    cyc(3);
    chk("play_done_once", 32'(done_seen), 1);
    chk("play_end_busy", 32'(bus.busy), 0);
    chk("play_end_note", 32'(bus.note_out), 0);

    // Learn: wrong key 4, then 3 (hit), rest skipped, then 5 (hit)
    bus.mode = 3'b001;
    cyc(2);
    done_seen = 0;
    bus.start = 1'b1;
    cyc(2);
    bus.start = 1'b0;
    chk("learn_busy", 32'(bus.busy), 1);
    chk("learn_led0", 32'(bus.led_out), 32'(7'b0000100));
    chk("learn_oct0", 32'(bus.octave_out), 2);
    bus.keys = 7'b0001000;
    cyc(1);
    chk("learn_echo", 32'(bus.note_out), 4);
    cyc(2);
    chk("learn_miss1", 32'(bus.misses), 1);
    bus.keys = '0;
    cyc(2);
    bus.keys = 7'b0000100;
    cyc(3);
    chk("learn_led2", 32'(bus.led_out), 32'(7'b0010000));
    chk("learn_hit1", 32'(bus.hits), 1);
    bus.keys = '0;
    cyc(2);
    bus.keys = 7'b0010000;
    cyc(3);
    bus.keys = '0;
    cyc(2);
    chk("learn_hits", 32'(bus.hits), 2);
    chk("learn_misses", 32'(bus.misses), 1);
    chk("learn_done", 32'(done_seen), 1);
    chk("learn_end_busy", 32'(bus.busy), 0);

    // Full buffer: alternate notes every tick
    bus.mode     = 3'b100;
    bus.octave   = 2'd1;
    bus.write_on = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.keys = (k % 2 == 1) ? 7'b0000010 : 7'b0000001;
      cyc(4);
    end
    chk("full_busy", 32'(bus.busy), 0);
    chk("full_flag", 32'(bus.rec_full), 1);
    chk("full_count", 32'(bus.event_count), 4);
    bus.write_on = 1'b0;
    bus.keys     = '0;
    cyc(3);
    chk("full_flag_hold", 32'(bus.rec_full), 1);

    // Abort mid-playback by leaving auto mode
    bus.mode = 3'b010;
    cyc(2);
    done_seen = 0;
    bus.start = 1'b1;
    cyc(2);
    chk("abort_busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    bus.mode  = 3'b000;
    cyc(1);
    chk("abort_idle", 32'(bus.busy), 0);
    chk("abort_note", 32'(bus.note_out), 0);
    chk("abort_led", 32'(bus.led_out), 0);
    cyc(20);
    chk("abort_no_done", 32'(done_seen), 0);

    // Asynchronous reset mid-recording
    bus.mode     = 3'b100;
    bus.octave   = 2'd1;
    bus.keys     = 7'b0000001;
    bus.write_on = 1'b1;
    cyc(3);
    chk("rst_rec_busy", 32'(bus.busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_note", 32'(bus.note_out), 0);
    chk("arst_oct", 32'(bus.octave_out), 0);
    chk("arst_led", 32'(bus.led_out), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_count", 32'(bus.event_count), 0);
    chk("arst_hits", 32'(bus.hits), 0);
    chk("arst_full", 32'(bus.rec_full), 0);
    cyc(2);
    reset        = 1'b0;
    bus.write_on = 1'b0;
    bus.keys     = '0;
    bus.mode     = 3'b010;
    cyc(3);
    done_seen = 0;
    busy_max  = 1'b0;
    bus.start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc(1);
      if (bus.busy === 1'b1) busy_max = 1'b1;
    end
    bus.start = 1'b0;
    chk("empty_start_busy", 32'(busy_max), 0);
    chk("empty_start_done", 32'(done_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piano_sequencer.md
# piano_sequencer

Parametrised successor of the piano controller core. It provides free play over `N_KEYS` keys, records the player's performance into an on-chip event buffer, and replays that buffer in two ways: auto (hands-off playback) or learn (waits for the matching key at each step). It sits between the key/switch inputs and the tone generator, driving the note code, octave and key LEDs that the buzzer and seven-segment blocks consume.

## Interface
- `N_KEYS`, default 7: number of piano keys; note codes are 1..N_KEYS, 0 = rest.
- `DEPTH`, default 64: recorded-event capacity, power of two.
- `DUR_W`, default 12: event duration width, in ticks.
- `TICK_DIV`, default 100000: clk cycles per tick (1 ms at 100 MHz).
- Derived: `NOTE_W` = clog2(N_KEYS+1); `AW` = clog2(DEPTH).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `keys` in N_KEYS: key levels; bit i = note i+1.
- `octave` in 2: octave switch, used in free play and recording.
- `mode` in 3: 100 = free, 010 = auto, 001 = learn; any other value = idle/silent.
- `write_on` in 1: level; record while high and mode = free.
- `start` in 1: level; a rising edge starts playback in auto/learn.
- `note_out` out NOTE_W: note code to the buzzer.
- `octave_out` out 2: octave to the buzzer.
- `led_out` out N_KEYS: key LEDs, one-hot or zero.
- `busy` out 1: recording or playing.
- `rec_full` out 1: buffer filled during the last recording.
- `event_count` out AW+1: number of stored events.
- `hits`, `misses` out 8 each: learn-mode scores, saturating at 255.
- `done` out 1: one-cycle pulse at the end of playback.

## Operation
- Key encoding: `cur_note` = index+1 of the lowest set key bit, 0 if no key is pressed.
- Tick: a free-running counter over 0..TICK_DIV-1. It pulses `tick` when it wraps.
- Edge detect: `start` and `write_on` are registered once; edges are taken from the registered copy.
- States are IDLE, REC, PLAY, LEARN.
- IDLE:
  - In free mode, `note_out` = cur_note, `octave_out` = octave, `led_out` = keys.
  - In any other mode, outputs are 0.
  - A `write_on` rise in free mode enters REC: `event_count` ← 0, `rec_full` ← 0, open event {cur_note, octave, dur = 0}.
  - A `start` rise in auto enters PLAY, or in learn enters LEARN, at event 0. This happens only if event_count > 0; otherwise stay in IDLE with no `done` pulse.
- REC:
  - Outputs behave as in free mode.
  - On each tick:
    - If {cur_note, octave} equals the open event, dur += 1, saturating at 2^DUR_W − 1.
    - Otherwise, write the open event to mem[event_count], increment event_count, and open a new event with dur = 1.
  - When event_count reaches DEPTH: `rec_full` ← 1, return to IDLE, and drop the open event.
  - On a `write_on` fall, or when mode leaves free: flush the open event if dur > 0 and the buffer is not full, then go to IDLE.
- PLAY:
  - `note_out`/`octave_out` come from the current event; `led_out` is one-hot of its note, or zero for a rest.
  - Ticks are counted; after dur ticks, advance to the next event.
  - After the last event: pulse `done`, zero the outputs, go to IDLE.
- LEARN:
  - Rest events are skipped after one cycle.
  - `led_out` shows the target note; `octave_out` is the event octave.
  - `note_out` = cur_note while any key is held, so the player hears what they press.
  - On a cur_note change to a nonzero value:
    - If it matches the target, hits += 1 and advance.
    - Otherwise, misses += 1.
  - After the last event: pulse `done`, go to IDLE.
  - A `start` rise while in PLAY or LEARN clears nothing.
  - hits/misses clear at each entry to LEARN.
- Leaving the active mode mid-PLAY/LEARN aborts immediately: go to IDLE, outputs follow IDLE rules, no `done` pulse.
- `busy` = 1 in REC, PLAY and LEARN.
- Reset: state IDLE; all outputs 0; event_count, hits, misses and rec_full 0; tick counter 0. Memory contents are not cleared.

## Timing
- All outputs are registered.
- Free play: `note_out` reflects `keys` 1 cycle after they change.
- `start`/`write_on` edges act 2 cycles after the input rises: 1 cycle for the sync register, 1 for the state/output register.
- Mem write completes in the tick cycle. The written event is readable by PLAY on the next cycle.
- Recorded and replayed durations are measured on the free-running tick, so accuracy is ±1 tick.
- A tick and a `write_on` fall in the same cycle: the tick update is applied first, then the flush.
- Auto playback at event boundaries: the next event's outputs appear in the cycle after the dur-th tick, with no silent gap.
- Reset is asynchronous; outputs go to 0 without waiting for `clk`. Deassertion is synchronised externally.

## Test plan
- **Free play** (TICK_DIV=4): keys = 0000101 → `note_out` = 1, `led_out` = 0000101 one cycle later; keys = 0 → `note_out` = 0.
- **Record** (TICK_DIV=4): write_on high, hold key 3 for 5 ticks, release for 2 ticks, key 5 for 3 ticks, write_on low → event_count = 3, events {3,5}, {0,2}, {5,3}, each dur ±1.
- **Auto playback**: mode = 010, start pulse → `note_out` sequence 3, 0, 5 with matching tick lengths, then `done` for exactly 1 cycle and `busy` = 0.
- **Learn**: mode = 001, start; press key 4 (wrong), then key 3, then key 5 → misses = 1, hits = 2, rest skipped, `done` pulses.
- **Full buffer** (DEPTH=4): alternate notes every tick while recording → event_count = 4, `rec_full` = 1, state returns to IDLE while write_on is still high.
- **Abort and reset**: change mode mid-PLAY → outputs 0, no `done`; assert reset mid-REC → all outputs 0 immediately, event_count = 0; start in auto → no `busy`.
